// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Merges the single-cycle ALU result path and the variable-latency load path
//   onto the one register-file write port. Load results that lose arbitration
//   wait in a small FIFO. A starvation counter forces a FIFO pop (by stalling
//   the ALU) once the queue has lost STARVE_LIMIT consecutive cycles.
//   RD_* are registered on the rising edge, so they are stable before the
//   register file commits on the falling edge.
//
// Ports
//   CLK, RST_N                   clock, asynchronous active-low reset
//   ALU_VALID/_RD_ADDRESS/_RD_DATA  ALU result (no backpressure)
//   ALU_STALL                    ALU must hold its result this cycle
//   MEM_VALID/MEM_READY          load-result handshake
//   MEM_RD_ADDRESS/MEM_RD_DATA   load destination and data
//   RD_ADDRESS/RD_DATA/RD_WRITE_EN  register-file write port
//   FIFO_COUNT                   number of queued load results
module writeback_arbiter #(
  parameter int REGISTER_WIDTH = 32,
  parameter int REGISTER_DEPTH = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              ALU_VALID,
  input  logic [$clog2(REGISTER_DEPTH)-1:0] ALU_RD_ADDRESS,
  input  logic [REGISTER_WIDTH-1:0]         ALU_RD_DATA,
  output logic                              ALU_STALL,
  input  logic                              MEM_VALID,
  output logic                              MEM_READY,
  input  logic [$clog2(REGISTER_DEPTH)-1:0] MEM_RD_ADDRESS,
  input  logic [REGISTER_WIDTH-1:0]         MEM_RD_DATA,
  output logic [$clog2(REGISTER_DEPTH)-1:0] RD_ADDRESS,
  output logic [REGISTER_WIDTH-1:0]         RD_DATA,
  output logic                              RD_WRITE_EN,
  output logic [$clog2(FIFO_DEPTH):0]       FIFO_COUNT
);

  localparam int AW = $clog2(REGISTER_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = 4;
  localparam int EW = AW + REGISTER_WIDTH;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [SW-1:0]             starve_q, starve_d;
  logic                      rd_we_q, rd_we_d;
  logic [AW-1:0]             rd_addr_q, rd_addr_d;
  logic [REGISTER_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [EW-1:0]             fifo_mem_q [FIFO_DEPTH];

  logic          fifo_empty;
  logic          mem_xfer;
  logic          alu_win;
  logic          pop;
  logic          bypass;
  logic          push;
  logic [EW-1:0] head;

  assign fifo_empty = (count_q == '0);
  // Ready is a function of state only; gated by reset so no transfer is
  // advertised while the arbiter is held in reset.
  assign MEM_READY  = RST_N && (count_q != FULL_COUNT);
  assign ALU_STALL  = (starve_q == STARVE_MAX) && !fifo_empty;
  assign mem_xfer   = MEM_VALID && MEM_READY;
  assign alu_win    = ALU_VALID && !ALU_STALL;
  assign pop        = !alu_win && !fifo_empty;
  assign bypass     = !alu_win && fifo_empty && mem_xfer;
  // Loads to x0 are accepted and dropped rather than occupying a slot.
  assign push       = mem_xfer && !bypass && (MEM_RD_ADDRESS != '0);
  assign head       = fifo_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    starve_d  = starve_q;
    rd_we_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    if (fifo_empty || pop)                     starve_d = '0;
    else if (alu_win && starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);

    // Address/data only move on a real write, so a no-write cycle holds them.
    if (alu_win) begin
      if (ALU_RD_ADDRESS != '0) begin
        rd_we_d   = 1'b1;
        rd_addr_d = ALU_RD_ADDRESS;
        rd_data_d = ALU_RD_DATA;
      end
    end else if (pop) begin
      rd_we_d   = 1'b1;
      rd_addr_d = head[EW-1:REGISTER_WIDTH];
      rd_data_d = head[REGISTER_WIDTH-1:0];
    end else if (bypass && MEM_RD_ADDRESS != '0) begin
      rd_we_d   = 1'b1;
      rd_addr_d = MEM_RD_ADDRESS;
      rd_data_d = MEM_RD_DATA;
    end
  end

  // ---- output / control register stage ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rd_we_q   <= rd_we_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // ---- FIFO storage: data only, validity is tracked by the pointers ----
  always_ff @(posedge CLK) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {MEM_RD_ADDRESS, MEM_RD_DATA};
  end

  assign RD_WRITE_EN = rd_we_q;
  assign RD_ADDRESS  = rd_addr_q;
  assign RD_DATA     = rd_data_q;
  assign FIFO_COUNT  = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ALU_VALID = 1'b0;
  logic [4:0]  ALU_RD_ADDRESS = '0;
  logic [31:0] ALU_RD_DATA = '0;
  logic        ALU_STALL;
  logic        MEM_VALID = 1'b0;
  logic        MEM_READY;
  logic [4:0]  MEM_RD_ADDRESS = '0;
  logic [31:0] MEM_RD_DATA = '0;
  logic [4:0]  RD_ADDRESS;
  logic [31:0] RD_DATA;
  logic        RD_WRITE_EN;
  logic [2:0]  FIFO_COUNT;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_arbiter #(
    .REGISTER_WIDTH(32), .REGISTER_DEPTH(32), .FIFO_DEPTH(4), .STARVE_LIMIT(3)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ALU_VALID(ALU_VALID), .ALU_RD_ADDRESS(ALU_RD_ADDRESS), .ALU_RD_DATA(ALU_RD_DATA),
    .ALU_STALL(ALU_STALL),
    .MEM_VALID(MEM_VALID), .MEM_READY(MEM_READY),
    .MEM_RD_ADDRESS(MEM_RD_ADDRESS), .MEM_RD_DATA(MEM_RD_DATA),
    .RD_ADDRESS(RD_ADDRESS), .RD_DATA(RD_DATA), .RD_WRITE_EN(RD_WRITE_EN),
    .FIFO_COUNT(FIFO_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_we"},   64'(RD_WRITE_EN), 64'd1);
    check({tag, "_addr"}, 64'(RD_ADDRESS),  64'(a));
    check({tag, "_data"}, 64'(RD_DATA),     64'(d));
  endtask

  initial begin
    // Reset state while RST_N is held low
    #12;
    check("rst_we",    64'(RD_WRITE_EN), 64'd0);
    check("rst_addr",  64'(RD_ADDRESS),  64'd0);
    check("rst_data",  64'(RD_DATA),     64'd0);
    check("rst_stall", 64'(ALU_STALL),   64'd0);
    check("rst_count", 64'(FIFO_COUNT),  64'd0);
    check("rst_ready", 64'(MEM_READY),   64'd0);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    #1 check("rel_ready", 64'(MEM_READY), 64'd1);

    // Single ALU write
    ALU_VALID = 1'b1; ALU_RD_ADDRESS = 5'd5; ALU_RD_DATA = 32'h1234;
    tick();
    check_wr("alu1", 5'd5, 32'h1234);
    ALU_VALID = 1'b0;
    tick();
    check("alu1_idle_we",   64'(RD_WRITE_EN), 64'd0);
    check("alu1_hold_addr", 64'(RD_ADDRESS),  64'd5);

    // Bypass of a load with an empty FIFO
    MEM_VALID = 1'b1; MEM_RD_ADDRESS = 5'd7; MEM_RD_DATA = 32'hDEAD;
    check("byp_ready", 64'(MEM_READY), 64'd1);
    tick();
    check_wr("byp", 5'd7, 32'hDEAD);
    check("byp_count", 64'(FIFO_COUNT), 64'd0);
    MEM_VALID = 1'b0;

    // Conflict, starvation stall and load ordering
    ALU_VALID = 1'b1; ALU_RD_ADDRESS = 5'd10; ALU_RD_DATA = 32'hA;
    MEM_VALID = 1'b1; MEM_RD_ADDRESS = 5'd1; MEM_RD_DATA = 32'h101;
    tick();
    check_wr("cf_alu0", 5'd10, 32'hA);
    check("cf_count1", 64'(FIFO_COUNT), 64'd1);
    MEM_RD_ADDRESS = 5'd2; MEM_RD_DATA = 32'h102;
    tick();
    check("cf_count2", 64'(FIFO_COUNT), 64'd2);
    check("cf_stall_a", 64'(ALU_STALL), 64'd0);
    MEM_RD_ADDRESS = 5'd3; MEM_RD_DATA = 32'h103;
    tick();
    check("cf_count3", 64'(FIFO_COUNT), 64'd3);
    check("cf_stall_b", 64'(ALU_STALL), 64'd0);
    MEM_VALID = 1'b0;
    tick();
    check_wr("cf_alu3", 5'd10, 32'hA);
    check("cf_stall1", 64'(ALU_STALL), 64'd1);
    tick();
    check_wr("cf_ld1", 5'd1, 32'h101);
    check("cf_stall1_off", 64'(ALU_STALL), 64'd0);
    check("cf_count_p1", 64'(FIFO_COUNT), 64'd2);
    repeat (3) tick();
    check("cf_stall2", 64'(ALU_STALL), 64'd1);
    tick();
    check_wr("cf_ld2", 5'd2, 32'h102);
    check("cf_count_p2", 64'(FIFO_COUNT), 64'd1);
    repeat (3) tick();
    check("cf_stall3", 64'(ALU_STALL), 64'd1);
    tick();
    check_wr("cf_ld3", 5'd3, 32'h103);
    check("cf_count_p3", 64'(FIFO_COUNT), 64'd0);
    check("cf_stall_end", 64'(ALU_STALL), 64'd0);
    ALU_VALID = 1'b0;
    tick();

    // Full FIFO: MEM_READY drops at 4 entries and returns after the stall-pop
    ALU_VALID = 1'b1; ALU_RD_ADDRESS = 5'd20; ALU_RD_DATA = 32'hC;
    MEM_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      MEM_RD_ADDRESS = 5'(11 + i); MEM_RD_DATA = 32'(32'h211 + i);
      tick();
    end
    check("full_count", 64'(FIFO_COUNT), 64'd4);
    check("full_ready", 64'(MEM_READY),  64'd0);
    check("full_stall", 64'(ALU_STALL),  64'd1);
    MEM_RD_ADDRESS = 5'd15; MEM_RD_DATA = 32'h215;
    tick();
    check_wr("full_pop", 5'd11, 32'h211);
    check("full_count_pop", 64'(FIFO_COUNT), 64'd3);
    check("full_ready_back", 64'(MEM_READY), 64'd1);
    tick();
    check_wr("full_alu", 5'd20, 32'hC);
    check("full_count_re", 64'(FIFO_COUNT), 64'd4);
    MEM_VALID = 1'b0; ALU_VALID = 1'b0;
    tick();
    check_wr("drain12", 5'd12, 32'h212);
    tick();
    check_wr("drain13", 5'd13, 32'h213);
    tick();
    check_wr("drain14", 5'd14, 32'h214);
    tick();
    check_wr("drain15", 5'd15, 32'h215);
    check("drain_count", 64'(FIFO_COUNT), 64'd0);
    tick();
    check("drain_idle_we", 64'(RD_WRITE_EN), 64'd0);

    // x0 filtering on both paths
    ALU_VALID = 1'b1; ALU_RD_ADDRESS = 5'd0; ALU_RD_DATA = 32'h55;
    MEM_VALID = 1'b1; MEM_RD_ADDRESS = 5'd0; MEM_RD_DATA = 32'h66;
    tick();
    check("x0_we_a",    64'(RD_WRITE_EN), 64'd0);
    check("x0_count_a", 64'(FIFO_COUNT),  64'd0);
    check("x0_ready_a", 64'(MEM_READY),   64'd1);
    check("x0_hold_a",  64'(RD_ADDRESS),  64'd15);
    ALU_VALID = 1'b0;
    tick();
    check("x0_we_b",    64'(RD_WRITE_EN), 64'd0);
    check("x0_count_b", 64'(FIFO_COUNT),  64'd0);
    check("x0_data_b",  64'(RD_DATA),     64'h215);
    MEM_VALID = 1'b0;

    // Asynchronous reset with three queued loads and ALU_STALL high
    ALU_VALID = 1'b1; ALU_RD_ADDRESS = 5'd9; ALU_RD_DATA = 32'h9;
    MEM_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      MEM_RD_ADDRESS = 5'(4 + i); MEM_RD_DATA = 32'(32'h304 + i);
      tick();
    end
    MEM_VALID = 1'b0;
    tick();
    check("ar_pre_count", 64'(FIFO_COUNT), 64'd3);
    check("ar_pre_stall", 64'(ALU_STALL),  64'd1);
    check("ar_pre_we",    64'(RD_WRITE_EN), 64'd1);
    ALU_VALID = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    check("ar_we",    64'(RD_WRITE_EN), 64'd0);
    check("ar_stall", 64'(ALU_STALL),   64'd0);
    check("ar_count", 64'(FIFO_COUNT),  64'd0);
    check("ar_ready", 64'(MEM_READY),   64'd0);
    check("ar_addr",  64'(RD_ADDRESS),  64'd0);
    #8 RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ar_post_we",    64'(RD_WRITE_EN), 64'd0);
      check("ar_post_count", 64'(FIFO_COUNT),  64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
